// File: rtl/dili_mont_exit.sv
// Streaming Montgomery-domain exit for Dilithium coefficients: y = x * 2^-32 mod Q.
// Three-stage valid/ready pipeline, one coefficient per cycle, with a per-polynomial last flag.
module dili_mont_exit #(
  parameter int DATA_WIDTH = 32,
  parameter int QINV       = 58728449,
  parameter int Q          = 8380417,
  parameter int N          = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [22:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [22:0] out_data_o,
  output logic        out_last_o,
  output logic        range_err_o
);

  localparam int XW = 23;
  localparam int TW = XW + DATA_WIDTH + 2;
  localparam int RW = TW - DATA_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Handshake: a transfer happens on valid & ready at either port. The whole pipe
  // freezes only when stage 3 holds a result the consumer refuses; in_ready_o is
  // derived from that stall alone, so it never depends on in_valid_i.
  logic stall;
  logic accept;

  logic                  s1_valid, s2_valid, s3_valid;
  logic [DATA_WIDTH-1:0] s1_m;
  logic [XW-1:0]         s1_x;
  logic [TW-1:0]         s2_t;
  logic [XW-1:0]         s3_y;
  logic                  s1_last, s2_last, s3_last;
  logic [CW-1:0]         cnt;
  logic                  range_err;

  logic                  last_c;
  logic [DATA_WIDTH-1:0] m_c;
  logic [TW-1:0]         mq_c;
  logic [TW-1:0]         t_c;
  logic signed [RW-1:0]  r_c;
  logic [RW-1:0]         y_wide;
  logic [XW-1:0]         y_c;
  logic                  unused_bits;

  assign stall      = s3_valid & ~out_ready_i;
  assign in_ready_o = ~stall;
  assign accept     = in_valid_i & in_ready_o;
  assign last_c     = (cnt == CW'(N - 1));

  // S1: m is chosen so that x - m*Q is divisible by the radix.
  assign m_c = DATA_WIDTH'(in_data_i) * DATA_WIDTH'(QINV);

  // S2: full-width signed difference; the low DATA_WIDTH bits are exactly zero.
  assign mq_c = TW'(s1_m) * TW'(Q);
  assign t_c  = TW'(s1_x) - mq_c;

  // S3: exact division by the radix gives -Q < r <= 0; lift negatives into [0, Q).
  assign r_c    = s2_t[TW-1:DATA_WIDTH];
  assign y_wide = r_c[RW-1] ? RW'(r_c + RW'(Q)) : r_c;
  assign y_c    = y_wide[XW-1:0];

  assign unused_bits = ^{s2_t[DATA_WIDTH-1:0], y_wide[RW-1:XW]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s1_m      <= '0;
      s1_x      <= '0;
      s2_t      <= '0;
      s3_y      <= '0;
      s1_last   <= 1'b0;
      s2_last   <= 1'b0;
      s3_last   <= 1'b0;
      cnt       <= '0;
      range_err <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= last_c ? '0 : cnt + CW'(1);
        if (in_data_i >= XW'(Q)) range_err <= 1'b1;
      end
      if (!stall) begin
        s1_valid <= in_valid_i;
        s1_m     <= m_c;
        s1_x     <= in_data_i;
        s1_last  <= last_c;
        s2_valid <= s1_valid;
        s2_t     <= t_c;
        s2_last  <= s1_last;
        s3_valid <= s2_valid;
        s3_y     <= y_c;
        s3_last  <= s2_last;
      end
    end
  end

  assign out_valid_o = s3_valid;
  assign out_data_o  = s3_y;
  assign out_last_o  = s3_last;
  assign range_err_o = range_err;

endmodule
